// File: rtl/ahb_interconnect.sv
// rtl/ahb_interconnect.sv - AHB-Lite single-master interconnect with decoder, response mux, default slave and error counter
//
// Ports:
//   Clk, Rst        system clock, synchronous active-high reset
//   hAddr, hTrans   master address-phase signals
//   hRdata_s        packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   hReadyout_s     per-slave HREADYOUT
//   hResp_s         per-slave HRESP (1 = ERROR)
//   hSel            one-hot slave select, decoded from hAddr only
//   hReady          muxed ready to the master, also broadcast to all slaves
//   hRdata, hResp   muxed read data and response to the master
//   err_clr         synchronous clear of err_cnt (wins over increment)
//   err_cnt         saturating count of completed ERROR responses

module ahb_interconnect #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int BASE_SHIFT = 28,
    parameter int CNT_W      = 16
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [ADDR_W-1:0]            hAddr,
    input  logic [1:0]                   hTrans,
    input  logic [NUM_SLAVES*DATA_W-1:0] hRdata_s,
    input  logic [NUM_SLAVES-1:0]        hReadyout_s,
    input  logic [NUM_SLAVES-1:0]        hResp_s,
    output logic [NUM_SLAVES-1:0]        hSel,
    output logic                         hReady,
    output logic [DATA_W-1:0]            hRdata,
    output logic                         hResp,
    input  logic                         err_clr,
    output logic [CNT_W-1:0]             err_cnt
);

    localparam int IDX_W  = ADDR_W - BASE_SHIFT;
    localparam int DSEL_W = $clog2(NUM_SLAVES + 1);
    localparam logic [DSEL_W-1:0] DEF_IDX = DSEL_W'(NUM_SLAVES);

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} def_state_t;

    logic [IDX_W-1:0]  idx;
    logic [DSEL_W-1:0] dec_idx;
    logic [DSEL_W-1:0] dsel;
    logic              def_sel;
    logic              def_ready;
    logic              def_resp;
    logic              accept_def;
    def_state_t        state;

    // Address low bits and hTrans[0] play no part in decode.
    logic addr_unused;
    assign addr_unused = ^{hAddr[BASE_SHIFT-1:0], hTrans[0]};

    assign idx = hAddr[ADDR_W-1:BASE_SHIFT];

    // Region decode; any region without a mapped slave falls to the default slave.
    always_comb begin
        hSel    = '0;
        def_sel = 1'b1;
        dec_idx = DEF_IDX;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx == IDX_W'(i)) begin
                hSel[i] = 1'b1;
                def_sel = 1'b0;
                dec_idx = DSEL_W'(i);
            end
        end
    end

    // Response mux steered by the data-phase owner.
    always_comb begin
        hRdata = '0;
        hReady = def_ready;
        hResp  = def_resp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel == DSEL_W'(i)) begin
                hRdata = hRdata_s[i*DATA_W +: DATA_W];
                hReady = hReadyout_s[i];
                hResp  = hResp_s[i];
            end
        end
    end

    // Data-phase owner advances only when the current data phase completes.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dsel <= DEF_IDX;
        end else if (hReady) begin
            dsel <= dec_idx;
        end
    end

    // IDLE/BUSY to an unmapped region get a zero-wait OKAY; only NONSEQ/SEQ error out.
    assign accept_def = hReady && def_sel && hTrans[1];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            def_ready <= 1'b1;
            def_resp  <= 1'b0;
        end else begin
            case (state)
                ERR1: begin
                    state     <= ERR2;
                    def_ready <= 1'b1;
                    def_resp  <= 1'b1;
                end
                default: begin
                    // IDLE and ERR2 both accept the next transfer.
                    if (accept_def) begin
                        state     <= ERR1;
                        def_ready <= 1'b0;
                        def_resp  <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        def_ready <= 1'b1;
                        def_resp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // An ERROR is counted on its completing (hReady high) cycle only.
    always_ff @(posedge Clk) begin
        if (Rst || err_clr) begin
            err_cnt <= '0;
        end else if (hReady && hResp && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ahb_interconnect.sv
// tb/tb_ahb_interconnect.sv - self-checking bench for ahb_interconnect

module tb_ahb_interconnect;

    localparam int NS   = 4;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          Rst = 1'b1;
    logic [31:0]   hAddr = '0;
    logic [1:0]    hTrans = '0;
    logic [31:0]   sd [NS];
    logic [NS*32-1:0] hRdata_s;
    logic [NS-1:0] rdy = '1;
    logic [NS-1:0] rsp = '0;
    logic [NS-1:0] hSel;
    logic          hReady;
    logic [31:0]   hRdata;
    logic          hResp;
    logic          err_clr = 1'b0;
    logic [CW-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner of the current data phase (NS = default slave), remaining
    // ERROR cycles of a default-slave response, and the error tally.
    int m_tgt   = NS;
    int m_err   = 0;
    int m_cnt   = 0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    assign hRdata_s = {sd[3], sd[2], sd[1], sd[0]};

    ahb_interconnect #(
        .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32), .BASE_SHIFT(28), .CNT_W(CW)
    ) dut (
        .Clk(clk), .Rst(Rst), .hAddr(hAddr), .hTrans(hTrans),
        .hRdata_s(hRdata_s), .hReadyout_s(rdy), .hResp_s(rsp),
        .hSel(hSel), .hReady(hReady), .hRdata(hRdata), .hResp(hResp),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        return int'(a[31:28]);
    endfunction

    function automatic logic exp_ready();
        if (m_tgt < NS) return rdy[m_tgt];
        return (m_err != 2);
    endfunction

    function automatic logic exp_resp();
        if (m_tgt < NS) return rsp[m_tgt];
        return (m_err > 0);
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (m_tgt < NS) return sd[m_tgt];
        return 32'h0;
    endfunction

    function automatic logic [NS-1:0] exp_sel();
        int rg = region(hAddr);
        if (rg < NS) return NS'(1 << rg);
        return '0;
    endfunction

    always @(posedge clk) begin
        logic r, p;
        int   rg;
        r  = exp_ready();
        p  = exp_resp();
        rg = region(hAddr);
        if (Rst) begin
            m_valid <= 1'b1;
            m_tgt   <= NS;
            m_err   <= 0;
            m_cnt   <= 0;
        end else begin
            if (err_clr) m_cnt <= 0;
            else if (r && p && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            if (r) begin
                m_tgt <= (rg < NS) ? rg : NS;
                m_err <= (rg >= NS && hTrans[1]) ? 2 : 0;
            end else if (m_tgt == NS) begin
                m_err <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_hsel",   32'(hSel),    32'(exp_sel()));
            chk("model_hready", 32'(hReady),  32'(exp_ready()));
            chk("model_hresp",  32'(hResp),   32'(exp_resp()));
            chk("model_hrdata", hRdata,       exp_rdata());
            chk("model_errcnt", 32'(err_cnt), 32'(m_cnt));
        end
    end

    task automatic cyc(input bit rst, input logic [31:0] a, input logic [1:0] t,
                       input logic [NS-1:0] r, input logic [NS-1:0] p, input bit clr);
        @(posedge clk);
        #1;
        Rst = rst; hAddr = a; hTrans = t; rdy = r; rsp = p; err_clr = clr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        sd[0] = 32'h1111_1111;
        sd[1] = 32'h2222_2222;
        sd[2] = 32'hCAFE_F00D;
        sd[3] = 32'h4444_4444;

        // Reset, idle bus
        cyc(1, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("rst_hready", 32'(hReady), 32'd1);
        chk("rst_hresp",  32'(hResp),  32'd0);
        chk("rst_hrdata", hRdata,      32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_hsel",   32'(hSel),   32'b0001);

        // Read from slave 2 with one wait state
        cyc(0, 32'h2000_0010, 2'b10, 4'hF, 4'h0, 0);
        chk("s2_hsel", 32'(hSel), 32'b0100);
        cyc(0, 32'h0, 2'b00, 4'b1011, 4'h0, 0);
        chk("s2_wait", 32'(hReady), 32'd0);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("s2_ready", 32'(hReady), 32'd1);
        chk("s2_rdata", hRdata, 32'hCAFE_F00D);

        // Write to unmapped region
        cyc(0, 32'h7000_0000, 2'b10, 4'hF, 4'h0, 0);
        chk("def_hsel", 32'(hSel), 32'd0);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("def_e1", {30'd0, hReady, hResp}, 32'b01);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("def_e2", {30'd0, hReady, hResp}, 32'b11);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("def_ok", {30'd0, hReady, hResp}, 32'b10);
        chk("def_cnt", 32'(err_cnt), 32'd1);

        // Back-to-back default errors, second accepted in ERR2, then slave 1
        cyc(0, 32'h5000_0000, 2'b10, 4'hF, 4'h0, 1);
        cyc(0, 32'h5000_0000, 2'b10, 4'hF, 4'h0, 0);
        chk("b2b_e1a", {30'd0, hReady, hResp}, 32'b01);
        chk("b2b_clr", 32'(err_cnt), 32'd0);
        cyc(0, 32'h5000_0000, 2'b10, 4'hF, 4'h0, 0);
        chk("b2b_e2a", {30'd0, hReady, hResp}, 32'b11);
        cyc(0, 32'h1000_0000, 2'b10, 4'hF, 4'h0, 0);
        chk("b2b_e1b", {30'd0, hReady, hResp}, 32'b01);
        cyc(0, 32'h1000_0000, 2'b10, 4'hF, 4'h0, 0);
        chk("b2b_e2b", {30'd0, hReady, hResp}, 32'b11);
        chk("b2b_hsel", 32'(hSel), 32'b0010);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("b2b_s1", {30'd0, hReady, hResp}, 32'b10);
        chk("b2b_rdata", hRdata, 32'h2222_2222);
        chk("b2b_cnt", 32'(err_cnt), 32'd2);

        // Slave 0 ERROR responses until the counter saturates
        cyc(0, 32'h0, 2'b10, 4'hF, 4'h0, 0);
        for (int i = 0; i < CMAX + 2; i++) begin
            cyc(0, 32'h0, 2'b10, 4'b1110, 4'b0001, 0);
            cyc(0, 32'h0, 2'b10, 4'hF, 4'b0001, 0);
        end
        cyc(0, 32'h0, 2'b10, 4'b1110, 4'b0001, 0);
        chk("sat_cnt", 32'(err_cnt), 32'(CMAX));
        chk("sat_wait", 32'(hReady), 32'd0);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'b0001, 1);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("sat_clr", 32'(err_cnt), 32'd0);

        // Reset in ERR1
        cyc(0, 32'h7000_0000, 2'b10, 4'hF, 4'b0001, 0);
        cyc(1, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("rst_e1", {30'd0, hReady, hResp}, 32'b01);
        chk("rst_e1_cnt", 32'(err_cnt), 32'd1);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("rst_after", {30'd0, hReady, hResp}, 32'b10);
        chk("rst_after_cnt", 32'(err_cnt), 32'd0);
        chk("rst_after_rdata", hRdata, 32'd0);

        // BUSY to unmapped region gets OKAY
        cyc(0, 32'h9000_0000, 2'b01, 4'hF, 4'h0, 0);
        chk("busy_hsel", 32'(hSel), 32'd0);
        cyc(0, 32'h0, 2'b00, 4'hF, 4'h0, 0);
        chk("busy_ok", {30'd0, hReady, hResp}, 32'b10);

        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
